// File: rtl/seq_divider.sv
// Iterative restoring divider producing quotient and remainder, signed or unsigned, one quotient bit per clock.
// Latency: done high WIDTH+1 cycles after the accepting edge, or 1 cycle for divide-by-zero / signed MIN/-1.
// Backpressure: busy is high while an operation runs; start outside IDLE is dropped, never queued.
// Ports: clk/rst (sync, active-high); start, is_signed, dividend, divisor sampled in IDLE;
//        busy, done (1-cycle pulse), quotient, remainder, div_by_zero (held until next completion).
module seq_divider #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] q_reg;     // holds |dividend| initially, quotient bits shift in from the right
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] dmag;
    logic [WIDTH-1:0] a_raw;     // original dividend, returned as remainder on divide-by-zero
    logic             neg_q;
    logic             neg_r;
    logic             dz_flag;
    logic             ovf_flag;

    // Operand decode, only meaningful in IDLE when start is sampled
    logic             a_neg, b_neg, in_dz, in_ovf;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        a_neg  = is_signed & dividend[WIDTH-1];
        b_neg  = is_signed & divisor[WIDTH-1];
        a_mag  = a_neg ? (~dividend + 1'b1) : dividend;
        b_mag  = b_neg ? (~divisor + 1'b1) : divisor;
        in_dz  = (divisor == '0);
        in_ovf = is_signed && (dividend == MIN_VAL) && (divisor == '1);
    end

    // One restoring step. The partial remainder is always < |divisor| before
    // the shift, so the shifted value fits in WIDTH+1 bits and, when the trial
    // goes negative, the kept value fits back into WIDTH bits.
    logic [WIDTH:0] shifted, trial;

    always_comb begin
        shifted = {rem_reg, q_reg[WIDTH-1]};
        trial   = shifted - {1'b0, dmag};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            q_reg       <= '0;
            rem_reg     <= '0;
            dmag        <= '0;
            a_raw       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz_flag     <= 1'b0;
            ovf_flag    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        cnt      <= '0;
                        rem_reg  <= '0;
                        q_reg    <= a_mag;
                        dmag     <= b_mag;
                        a_raw    <= dividend;
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        dz_flag  <= in_dz;
                        ovf_flag <= in_ovf;
                        state    <= (in_dz || in_ovf) ? FINISH : CALC;
                    end
                end
                CALC: begin
                    if (!trial[WIDTH]) begin
                        rem_reg <= trial[WIDTH-1:0];
                        q_reg   <= {q_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_reg <= shifted[WIDTH-1:0];
                        q_reg   <= {q_reg[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1))
                        state <= FINISH;
                end
                FINISH: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                    if (dz_flag) begin
                        quotient    <= '1;
                        remainder   <= a_raw;
                        div_by_zero <= 1'b1;
                    end else if (ovf_flag) begin
                        quotient    <= MIN_VAL;
                        remainder   <= '0;
                        div_by_zero <= 1'b0;
                    end else begin
                        // Quotient negative when signs differ; remainder follows the dividend
                        quotient    <= neg_q ? (~q_reg + 1'b1) : q_reg;
                        remainder   <= neg_r ? (~rem_reg + 1'b1) : rem_reg;
                        div_by_zero <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    localparam int W = 64;
    localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ONES = {W{1'b1}};

    logic         clk = 1'b0;
    logic         rst, start, is_signed;
    logic [W-1:0] dividend, divisor;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int compared   = 0;
    int mismatched = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on magnitudes, truncating toward zero.
    task automatic model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output int lat);
        logic [W-1:0] ma, mb, uq, ur;
        dz  = 1'b0;
        lat = W + 1;
        if (b == 0) begin
            q = ONES; r = a; dz = 1'b1; lat = 1;
        end else if (s && a == MINV && b == ONES) begin
            q = MINV; r = 0; lat = 1;
        end else if (!s) begin
            q = a / b; r = a % b;
        end else begin
            ma = a[W-1] ? -a : a;
            mb = b[W-1] ? -b : b;
            uq = ma / mb;
            ur = ma % mb;
            q  = (a[W-1] ^ b[W-1]) ? -uq : uq;
            r  = a[W-1] ? -ur : ur;
        end
    endtask

    // Called #1 after a posedge: presents operands, lets the next edge accept them.
    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        is_signed = s; dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dividend = {$urandom, $urandom};
        divisor  = {$urandom, $urandom};
        is_signed = $urandom_range(0, 1);
    endtask

    // Counts edges after the accepting edge until done is seen; 0 means timeout.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    typedef struct {
        logic         s;
        logic [W-1:0] a, b, q, r;
        logic         dz;
        int           lat;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [W-1:0] eq, er, a, b, held_q;
        logic         edz, s;
        int           elat, lat;

        tbl[0]  = '{1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 65};
        tbl[1]  = '{1'b1, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, ONES, 1'b0, 65};
        tbl[2]  = '{1'b1, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 1'b0, 65};
        tbl[3]  = '{1'b0, 64'h1234, 64'd0, ONES, 64'h1234, 1'b1, 1};
        tbl[4]  = '{1'b1, MINV, ONES, MINV, 64'd0, 1'b0, 1};
        tbl[5]  = '{1'b0, ONES, 64'd1, ONES, 64'd0, 1'b0, 65};
        tbl[6]  = '{1'b0, 64'd5, ONES, 64'd0, 64'd5, 1'b0, 65};
        tbl[7]  = '{1'b1, -64'sd7, 64'd0, ONES, -64'sd7, 1'b1, 1};
        tbl[8]  = '{1'b0, MINV, ONES, 64'd0, MINV, 1'b0, 65};
        tbl[9]  = '{1'b1, MINV, 64'd1, MINV, 64'd0, 1'b0, 65};
        tbl[10] = '{1'b1, -64'sd8, -64'sd3, 64'd2, -64'sd2, 1'b0, 65};

        rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_quot", quotient, 64'd0);
        chk("reset_rem", remainder, 64'd0);
        chk("reset_dz", 64'(div_by_zero), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table
        foreach (tbl[i]) begin
            issue(tbl[i].s, tbl[i].a, tbl[i].b);
            chk($sformatf("tbl%0d_busy_after_accept", i), 64'(busy), 64'd1);
            wait_done(lat);
            chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
            chk($sformatf("tbl%0d_quot", i), quotient, tbl[i].q);
            chk($sformatf("tbl%0d_rem", i), remainder, tbl[i].r);
            chk($sformatf("tbl%0d_dz", i), 64'(div_by_zero), 64'(tbl[i].dz));
            chk($sformatf("tbl%0d_busy_at_done", i), 64'(busy), 64'd0);
        end

        // Results hold after the done pulse
        held_q = quotient;
        @(posedge clk); #1;
        chk("hold_done_low", 64'(done), 64'd0);
        chk("hold_quot", quotient, held_q);

        // start pulsed mid-operation is dropped
        issue(1'b0, 64'd100, 64'd7);
        repeat (9) begin @(posedge clk); #1; end
        is_signed = 1'b0; dividend = 64'd50; divisor = 64'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        for (int i = 11; i <= 200; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i; break; end
        end
        chk("ignored_start_latency", 64'(lat), 64'd65);
        chk("ignored_start_quot", quotient, 64'd14);
        chk("ignored_start_rem", remainder, 64'd2);
        @(posedge clk); #1;
        chk("ignored_start_not_queued", 64'(busy), 64'd0);

        // Reset during an operation
        issue(1'b1, -64'sd1000, 64'd9);
        repeat (29) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_quot", quotient, 64'd0);
        chk("midrst_rem", remainder, 64'd0);
        chk("midrst_dz", 64'(div_by_zero), 64'd0);

        // start together with rst is ignored
        rst = 1'b1; start = 1'b1; is_signed = 1'b0; dividend = 64'd9; divisor = 64'd0;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        chk("start_with_rst_busy", 64'(busy), 64'd0);
        chk("start_with_rst_done", 64'(done), 64'd0);

        // New operation after reset
        issue(1'b1, -64'sd1000, 64'd9);
        wait_done(lat);
        chk("postrst_latency", 64'(lat), 64'd65);
        chk("postrst_quot", quotient, -64'sd111);
        chk("postrst_rem", remainder, -64'sd1);

        // Random back-to-back regression against the reference model
        for (int n = 0; n < 500; n++) begin
            s = $urandom_range(0, 1);
            case ($urandom_range(0, 7))
                0: b = 64'd0;
                1: b = ONES;
                2: b = 64'($urandom_range(1, 20));
                3: b = {32'd0, $urandom};
                default: b = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 5))
                0: a = MINV;
                1: a = 64'($urandom_range(0, 100));
                default: a = {$urandom, $urandom};
            endcase
            model(s, a, b, eq, er, edz, elat);
            issue(s, a, b);
            wait_done(lat);
            compared++;
            if (lat != elat || quotient !== eq || remainder !== er || div_by_zero !== edz) begin
                mismatched++;
                $display("FAIL rand%0d s=%0b a=%h b=%h: got q=%h r=%h dz=%0b lat=%0d expected q=%h r=%h dz=%0b lat=%0d",
                         n, s, a, b, quotient, remainder, div_by_zero, lat, eq, er, edz, elat);
            end
            compared++;
            if (a !== quotient * b + remainder) begin
                mismatched++;
                $display("FAIL rand%0d_invariant: q*b+r=%h dividend=%h", n, quotient * b + remainder, a);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
